// File: rtl/exc_ctrl.sv
// MEM-stage exception collector: merges instruction exception flags with pending
// interrupts, drives CP0 exception entry, then issues a registered flush/redirect.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic        inst_adel_i,
  input  logic        ri_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        eret_i,
  input  logic        ov_i,
  input  logic        trap_i,
  input  logic        load_adel_i,
  input  logic        store_ades_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic        int_req_r, int_req_nxt_s;
  logic        flush_nxt_s;
  logic [31:0] new_pc_nxt_s;
  logic [31:0] status_f_s, cause_f_s, epc_f_s;
  logic        any_flag_s, take_s;
  logic [31:0] code_s, bad_s;

  // CP0 view with same-cycle WB mtc0 writes forwarded in
  always_comb begin
    status_f_s = cp0_status_i;
    cause_f_s  = cp0_cause_i;
    epc_f_s    = cp0_epc_i;
    if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd12)) begin
      status_f_s = wb_cp0_data_i;
    end else begin
      status_f_s = cp0_status_i;
    end
    if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd13)) begin
      cause_f_s = {cp0_cause_i[31:10], wb_cp0_data_i[9:8], cp0_cause_i[7:0]};
    end else begin
      cause_f_s = cp0_cause_i;
    end
    if (wb_cp0_we_i && (wb_cp0_waddr_i == 5'd14)) begin
      epc_f_s = wb_cp0_data_i;
    end else begin
      epc_f_s = cp0_epc_i;
    end
  end

  assign int_req_nxt_s = (|(cause_f_s[15:8] & status_f_s[15:8])) & status_f_s[0] & ~status_f_s[1];

  assign any_flag_s = inst_adel_i | ri_i | syscall_i | break_i | eret_i |
                      ov_i | trap_i | load_adel_i | store_ades_i;
  assign take_s = ~rst & (state_r == IDLE) & valid_i & ~stall_i & (int_req_r | any_flag_s);

  // Priority encoder: the interrupt request beats every instruction flag
  always_comb begin
    code_s = 32'd0;
    bad_s  = 32'd0;
    if (int_req_r) begin
      code_s = 32'h1;
    end else if (inst_adel_i) begin
      code_s = 32'h4;
      bad_s  = pc_i;
    end else if (ri_i) begin
      code_s = 32'ha;
    end else if (syscall_i) begin
      code_s = 32'h8;
    end else if (break_i) begin
      code_s = 32'h9;
    end else if (eret_i) begin
      code_s = 32'he;
    end else if (ov_i) begin
      code_s = 32'hc;
    end else if (trap_i) begin
      code_s = 32'hd;
    end else if (load_adel_i) begin
      code_s = 32'h4;
      bad_s  = mem_addr_i;
    end else if (store_ades_i) begin
      code_s = 32'h5;
      bad_s  = mem_addr_i;
    end else begin
      code_s = 32'd0;
      bad_s  = 32'd0;
    end
  end

  assign excepttype_o        = take_s ? code_s : 32'd0;
  assign bad_addr_o          = take_s ? bad_s : 32'd0;
  assign current_inst_addr_o = rst ? 32'd0 : pc_i;
  assign is_in_delayslot_o   = rst ? 1'b0 : is_in_delayslot_i;

  // Next-state and registered flush/redirect values
  always_comb begin
    state_nxt_s  = state_r;
    flush_nxt_s  = 1'b0;
    new_pc_nxt_s = new_pc_o;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          state_nxt_s  = FLUSH;
          flush_nxt_s  = 1'b1;
          new_pc_nxt_s = (code_s == 32'he) ? epc_f_s : EXC_VECTOR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FLUSH: begin
        state_nxt_s = IDLE;
        flush_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s = IDLE;
        flush_nxt_s = 1'b0;
      end
    endcase
  end

  // State, interrupt request and flush/redirect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      int_req_r <= 1'b0;
      flush_o   <= 1'b0;
      new_pc_o  <= 32'd0;
    end else begin
      state_r   <= state_nxt_s;
      int_req_r <= int_req_nxt_s;
      flush_o   <= flush_nxt_s;
      new_pc_o  <= new_pc_nxt_s;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl: hand-computed expectations checked
// with immediate assertions along one linear stimulus sequence.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_i, is_in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i;
  logic        inst_adel_i, ri_i, syscall_i, break_i, eret_i, ov_i, trap_i;
  logic        load_adel_i, store_ades_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] VEC = 32'hBFC00380;

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .inst_adel_i(inst_adel_i), .ri_i(ri_i),
    .syscall_i(syscall_i), .break_i(break_i), .eret_i(eret_i), .ov_i(ov_i),
    .trap_i(trap_i), .load_adel_i(load_adel_i), .store_ades_i(store_ades_i),
    .mem_addr_i(mem_addr_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_data_i(wb_cp0_data_i), .excepttype_o(excepttype_o),
    .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
    .bad_addr_o(bad_addr_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_i = 1'b0; stall_i = 1'b0; is_in_delayslot_i = 1'b0;
    pc_i = 32'd0; mem_addr_i = 32'd0;
    inst_adel_i = 1'b0; ri_i = 1'b0; syscall_i = 1'b0; break_i = 1'b0;
    eret_i = 1'b0; ov_i = 1'b0; trap_i = 1'b0; load_adel_i = 1'b0; store_ades_i = 1'b0;
    cp0_status_i = 32'd0; cp0_cause_i = 32'd0; cp0_epc_i = 32'd0;
    wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'd0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    valid_i = 1'b1; syscall_i = 1'b1; pc_i = 32'h1234_5678;
    tick();
    #1;
    chk("rst_exc", excepttype_o, 32'd0);
    chk("rst_pc", current_inst_addr_o, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_newpc", new_pc_o, 32'd0);
    tick();
    rst = 1'b0;
    clear_inputs();

    // syscall, then a flagged wrong-path instruction during FLUSH
    valid_i = 1'b1; syscall_i = 1'b1; pc_i = 32'hBFC00100;
    #1;
    chk("sys_code", excepttype_o, 32'h8);
    chk("sys_pc", current_inst_addr_o, 32'hBFC00100);
    chk("sys_bad", bad_addr_o, 32'd0);
    chk("sys_ds", {31'd0, is_in_delayslot_o}, 32'd0);
    tick();
    chk("sys_flush", {31'd0, flush_o}, 32'd1);
    chk("sys_newpc", new_pc_o, VEC);
    clear_inputs();
    valid_i = 1'b1; ri_i = 1'b1; pc_i = 32'hBFC00104;
    #1;
    chk("flush_ignore", excepttype_o, 32'd0);
    tick();
    chk("sys_flush_end", {31'd0, flush_o}, 32'd0);
    clear_inputs();

    // load address error in a delay slot
    valid_i = 1'b1; load_adel_i = 1'b1; mem_addr_i = 32'h80000003;
    pc_i = 32'hBFC00200; is_in_delayslot_i = 1'b1;
    #1;
    chk("ladel_code", excepttype_o, 32'h4);
    chk("ladel_bad", bad_addr_o, 32'h80000003);
    chk("ladel_ds", {31'd0, is_in_delayslot_o}, 32'd1);
    tick();
    chk("ladel_flush", {31'd0, flush_o}, 32'd1);
    clear_inputs();
    tick();

    // fetch address error outranks syscall; bad address is the PC
    valid_i = 1'b1; inst_adel_i = 1'b1; syscall_i = 1'b1; pc_i = 32'h00000002;
    mem_addr_i = 32'h0000_0010;
    #1;
    chk("iadel_code", excepttype_o, 32'h4);
    chk("iadel_bad", bad_addr_o, 32'h00000002);
    tick();
    clear_inputs();
    tick();

    // eret with forwarded EPC write
    valid_i = 1'b1; eret_i = 1'b1; cp0_epc_i = 32'h12345678;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'hBFC00200;
    #1;
    chk("eret_code", excepttype_o, 32'he);
    tick();
    chk("eret_newpc", new_pc_o, 32'hBFC00200);
    clear_inputs();
    tick();

    // interrupt: visible one cycle after IP/IE set
    valid_i = 1'b1; cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00000400;
    #1;
    chk("int_wait", excepttype_o, 32'd0);
    tick();
    chk("int_code", excepttype_o, 32'h1);
    chk("int_bad", bad_addr_o, 32'd0);
    tick();
    chk("int_flush", {31'd0, flush_o}, 32'd1);
    chk("int_newpc", new_pc_o, VEC);
    clear_inputs();
    tick();

    // EXL set masks the interrupt
    valid_i = 1'b1; cp0_status_i = 32'h0000FF03; cp0_cause_i = 32'h00000400;
    tick();
    chk("exl_code", excepttype_o, 32'd0);
    tick();
    chk("exl_flush", {31'd0, flush_o}, 32'd0);
    clear_inputs();
    tick();

    // ri+ov under stall, then released
    valid_i = 1'b1; ri_i = 1'b1; ov_i = 1'b1; stall_i = 1'b1;
    #1;
    chk("stall_code", excepttype_o, 32'd0);
    tick();
    chk("stall_flush", {31'd0, flush_o}, 32'd0);
    stall_i = 1'b0;
    #1;
    chk("unstall_code", excepttype_o, 32'ha);
    tick();
    chk("unstall_flush", {31'd0, flush_o}, 32'd1);
    clear_inputs();
    tick();

    // WB mtc0 clears IE while the request is already registered
    cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00000400;
    tick();
    valid_i = 1'b1;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'd0;
    #1;
    chk("ieclr_taken", excepttype_o, 32'h1);
    tick();
    tick();
    #1;
    chk("ieclr_gone", excepttype_o, 32'd0);
    clear_inputs();
    tick();

    // forwarded Cause software-interrupt bit raises a request
    cp0_status_i = 32'h00000101;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h00000100;
    tick();
    clear_inputs();
    valid_i = 1'b1;
    #1;
    chk("swint_code", excepttype_o, 32'h1);
    tick();
    clear_inputs();
    tick();

    // break, then reset during FLUSH
    valid_i = 1'b1; break_i = 1'b1; store_ades_i = 1'b1;
    #1;
    chk("brk_code", excepttype_o, 32'h9);
    tick();
    chk("brk_flush", {31'd0, flush_o}, 32'd1);
    clear_inputs();
    rst = 1'b1;
    tick();
    chk("rstfl_flush", {31'd0, flush_o}, 32'd0);
    chk("rstfl_newpc", new_pc_o, 32'd0);
    rst = 1'b0;
    valid_i = 1'b1; store_ades_i = 1'b1; mem_addr_i = 32'h80000006;
    #1;
    chk("ades_code", excepttype_o, 32'h5);
    chk("ades_bad", bad_addr_o, 32'h80000006);
    tick();
    clear_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
